warp_dispatcher: RTL and testbench

Receiving end of the warp scheduler's kernel-launch interface, one instance per SIMD core. Accepts kernel descriptors (start PC, thread count, warp ID) through a valid/ready handshake and holds them in a small resident-warp table. Issues one warp-instruction fetch request per cycle to the core front end, round-robin across resident warps. Retires warps on core exit notifications and returns each freed warp ID to the scheduler for its open-warp bookkeeping.

---
 rtl/warp_dispatcher_if.sv | 46 ++++
 rtl/warp_dispatcher.sv | 185 ++++++++++++++++++
 tb/tb_warp_dispatcher.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/warp_dispatcher_if.sv
// Kernel-launch, fetch-issue and exit/retire channels between one SIMD core's
// warp dispatcher and its scheduler/core front end.
interface warp_dispatcher_if #(
  parameter int THREAD_CNT_W = 3,
  parameter int WARP_ID_W    = 4,
  parameter int NUM_SLOTS    = 4
);
  localparam int MASK_W = 1 << THREAD_CNT_W;
  localparam int CNT_W  = $clog2(NUM_SLOTS + 1);

  logic                    valid_kernel;
  logic [THREAD_CNT_W-1:0] kernel_thread_count;
  logic [31:0]             kernel_start_pc;
  logic [WARP_ID_W-1:0]    kernel_warp_id;
  logic                    kernel_ready;
  logic                    kernel_error;

  logic                    issue_valid;
  logic                    issue_ready;
  logic [WARP_ID_W-1:0]    issue_warp_id;
  logic [31:0]             issue_pc;
  logic [MASK_W-1:0]       issue_thread_mask;

  logic                    exit_valid;
  logic [WARP_ID_W-1:0]    exit_warp_id;
  logic                    warp_done;
  logic [WARP_ID_W-1:0]    done_warp_id;
  logic                    exit_error;
  logic [CNT_W-1:0]        active_warps;

  // Scheduler / core side.
  modport master (
    output valid_kernel, kernel_thread_count, kernel_start_pc, kernel_warp_id,
    output issue_ready, exit_valid, exit_warp_id,
    input  kernel_ready, kernel_error, issue_valid, issue_warp_id, issue_pc,
    input  issue_thread_mask, warp_done, done_warp_id, exit_error, active_warps
  );

  // Dispatcher side.
  modport slave (
    input  valid_kernel, kernel_thread_count, kernel_start_pc, kernel_warp_id,
    input  issue_ready, exit_valid, exit_warp_id,
    output kernel_ready, kernel_error, issue_valid, issue_warp_id, issue_pc,
    output issue_thread_mask, warp_done, done_warp_id, exit_error, active_warps
  );
endinterface

// File: rtl/warp_dispatcher.sv
// Per-core warp dispatcher: resident-warp table fed by kernel descriptors,
// round-robin one-per-cycle fetch issue, and exit-driven warp retirement.
module warp_dispatcher #(
  parameter int THREAD_CNT_W = 3,
  parameter int WARP_ID_W    = 4,
  parameter int NUM_SLOTS    = 4
) (
  input logic               clk,
  input logic               rst,
  warp_dispatcher_if.slave  bus
);
  localparam int MASK_W = 1 << THREAD_CNT_W;
  localparam int PTR_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CNT_W  = $clog2(NUM_SLOTS + 1);

  typedef struct packed {
    logic                    valid;
    logic [WARP_ID_W-1:0]    warp_id;
    logic [31:0]             pc;
    logic [THREAD_CNT_W-1:0] thread_count;
  } slot_t;

  slot_t [NUM_SLOTS-1:0] slot_q, slot_d;
  logic [PTR_W-1:0]      rr_q, rr_d;
  logic                  issue_valid_q, issue_valid_d;
  logic [WARP_ID_W-1:0]  issue_warp_id_q, issue_warp_id_d;
  logic [31:0]           issue_pc_q, issue_pc_d;
  logic [MASK_W-1:0]     issue_mask_q, issue_mask_d;
  logic                  kernel_error_q, kernel_error_d;
  logic                  warp_done_q, warp_done_d;
  logic [WARP_ID_W-1:0]  done_warp_id_q, done_warp_id_d;
  logic                  exit_error_q, exit_error_d;

  logic                  any_free;
  logic [PTR_W-1:0]      free_idx;
  logic                  id_resident;
  logic                  exit_hit;
  logic [PTR_W-1:0]      exit_idx;
  logic [NUM_SLOTS-1:0]  eligible;
  logic                  sel_found;
  logic [PTR_W-1:0]      sel_idx;
  logic [CNT_W-1:0]      active_cnt;
  logic                  kernel_ready;

  function automatic logic [MASK_W-1:0] thread_mask(input logic [THREAD_CNT_W-1:0] n);
    logic [MASK_W-1:0] m;
    for (int t = 0; t < MASK_W; t++) m[t] = (t < int'(n));
    return m;
  endfunction

  // NOTE: every always_comb output gets a default before any branch; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    any_free    = 1'b0;
    free_idx    = '0;
    id_resident = 1'b0;
    exit_hit    = 1'b0;
    exit_idx    = '0;
    active_cnt  = '0;
    // Descending scan so the lowest free index is the one left standing.
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slot_q[i].valid) begin
        any_free = 1'b1;
        free_idx = PTR_W'(i);
      end
    end
    for (int i = 0; i < NUM_SLOTS; i++) begin
      active_cnt = active_cnt + CNT_W'(slot_q[i].valid);
      if (slot_q[i].valid && slot_q[i].warp_id == bus.kernel_warp_id) id_resident = 1'b1;
      if (bus.exit_valid && slot_q[i].valid && slot_q[i].warp_id == bus.exit_warp_id) begin
        exit_hit = 1'b1;
        exit_idx = PTR_W'(i);
      end
    end
  end

  // A warp retiring at this edge must not be handed to the front end.
  always_comb begin
    logic [PTR_W-1:0] j;
    eligible  = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    j         = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      eligible[i] = slot_q[i].valid && !(exit_hit && exit_idx == PTR_W'(i));
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      j = PTR_W'((int'(rr_q) + k) % NUM_SLOTS);
      if (eligible[j]) begin
        sel_found = 1'b1;
        sel_idx   = j;
      end
    end
  end

  assign kernel_ready = any_free && !rst;

  always_comb begin
    slot_d          = slot_q;
    rr_d            = rr_q;
    issue_valid_d   = issue_valid_q;
    issue_warp_id_d = issue_warp_id_q;
    issue_pc_d      = issue_pc_q;
    issue_mask_d    = issue_mask_q;
    kernel_error_d  = 1'b0;
    warp_done_d     = 1'b0;
    done_warp_id_d  = done_warp_id_q;
    exit_error_d    = 1'b0;

    // Allocation uses the pre-edge free list, so a slot freed by an exit at
    // this same edge is never reused until the next cycle.
    if (bus.valid_kernel && kernel_ready) begin
      if (bus.kernel_thread_count == '0 || id_resident) begin
        kernel_error_d = 1'b1;
      end else begin
        slot_d[free_idx] = '{valid: 1'b1, warp_id: bus.kernel_warp_id,
                             pc: bus.kernel_start_pc,
                             thread_count: bus.kernel_thread_count};
      end
    end

    if (!issue_valid_q || bus.issue_ready) begin
      issue_valid_d = sel_found;
      if (sel_found) begin
        issue_warp_id_d    = slot_q[sel_idx].warp_id;
        issue_pc_d         = slot_q[sel_idx].pc;
        issue_mask_d       = thread_mask(slot_q[sel_idx].thread_count);
        slot_d[sel_idx].pc = slot_q[sel_idx].pc + 32'd4;
        rr_d               = PTR_W'((int'(sel_idx) + 1) % NUM_SLOTS);
      end
    end else if (exit_hit && issue_warp_id_q == bus.exit_warp_id) begin
      issue_valid_d = 1'b0;
    end

    if (bus.exit_valid) begin
      if (exit_hit) begin
        slot_d[exit_idx].valid = 1'b0;
        warp_done_d            = 1'b1;
        done_warp_id_d         = bus.exit_warp_id;
      end else begin
        exit_error_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the slot table is a handful of flops, not a RAM, so the whole
      // entry is cleared; this keeps payload fields X-free after reset.
      slot_q          <= '0;
      rr_q            <= '0;
      issue_valid_q   <= 1'b0;
      issue_warp_id_q <= '0;
      issue_pc_q      <= '0;
      issue_mask_q    <= '0;
      kernel_error_q  <= 1'b0;
      warp_done_q     <= 1'b0;
      done_warp_id_q  <= '0;
      exit_error_q    <= 1'b0;
    end else begin
      slot_q          <= slot_d;
      rr_q            <= rr_d;
      issue_valid_q   <= issue_valid_d;
      issue_warp_id_q <= issue_warp_id_d;
      issue_pc_q      <= issue_pc_d;
      issue_mask_q    <= issue_mask_d;
      kernel_error_q  <= kernel_error_d;
      warp_done_q     <= warp_done_d;
      done_warp_id_q  <= done_warp_id_d;
      exit_error_q    <= exit_error_d;
    end
  end

  assign bus.kernel_ready      = kernel_ready;
  assign bus.kernel_error      = kernel_error_q;
  assign bus.issue_valid       = issue_valid_q;
  assign bus.issue_warp_id     = issue_warp_id_q;
  assign bus.issue_pc          = issue_pc_q;
  assign bus.issue_thread_mask = issue_mask_q;
  assign bus.warp_done         = warp_done_q;
  assign bus.done_warp_id      = done_warp_id_q;
  assign bus.exit_error        = exit_error_q;
  assign bus.active_warps      = active_cnt;
endmodule

// File: tb/tb_warp_dispatcher.sv
// Self-checking bench for warp_dispatcher: directed scenarios plus random
// traffic, all compared against a slot-table reference model.
module tb_warp_dispatcher;
  localparam int TW = 3;
  localparam int IW = 4;
  localparam int NS = 4;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  warp_dispatcher_if #(.THREAD_CNT_W(TW), .WARP_ID_W(IW), .NUM_SLOTS(NS)) bus ();
  warp_dispatcher #(.THREAD_CNT_W(TW), .WARP_ID_W(IW), .NUM_SLOTS(NS)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  bit          m_v   [NS];
  logic [3:0]  m_id  [NS];
  logic [31:0] m_pc  [NS];
  logic [2:0]  m_cnt [NS];
  int          m_rr;
  bit          m_iv;
  logic [3:0]  m_iid;
  logic [31:0] m_ipc;
  logic [7:0]  m_imask;
  bit          m_kerr, m_done, m_xerr;
  logic [3:0]  m_did;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic bit model_free();
    for (int i = 0; i < NS; i++) if (!m_v[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_active();
    int n = 0;
    for (int i = 0; i < NS; i++) n += int'(m_v[i]);
    return n;
  endfunction

  task automatic model_step(input bit r, input bit vk, input logic [2:0] c,
                            input logic [31:0] pc, input logic [3:0] id,
                            input bit ir, input bit ev, input logic [3:0] eid);
    int free_i, xs, sel, j;
    bit res;
    m_kerr = 0; m_done = 0; m_xerr = 0;
    if (r) begin
      for (int i = 0; i < NS; i++) m_v[i] = 0;
      m_rr = 0; m_iv = 0;
      return;
    end
    free_i = -1; xs = -1; res = 0;
    for (int i = 0; i < NS; i++) begin
      if (!m_v[i] && free_i < 0) free_i = i;
      if (m_v[i] && m_id[i] == id) res = 1;
      if (ev && m_v[i] && m_id[i] == eid) xs = i;
    end
    if (!(vk && free_i >= 0)) free_i = -1;
    else if (c == 0 || res) begin m_kerr = 1; free_i = -1; end
    if (!m_iv || ir) begin
      sel = -1;
      for (int k = 0; k < NS; k++) begin
        j = (m_rr + k) % NS;
        if (sel < 0 && m_v[j] && j != xs) sel = j;
      end
      m_iv = (sel >= 0);
      if (sel >= 0) begin
        m_iid   = m_id[sel];
        m_ipc   = m_pc[sel];
        m_imask = 8'((1 << m_cnt[sel]) - 1);
        m_pc[sel] = m_pc[sel] + 32'd4;
        m_rr = (sel + 1) % NS;
      end
    end else if (xs >= 0 && m_iid == eid) begin
      m_iv = 0;
    end
    if (ev) begin
      if (xs >= 0) begin m_v[xs] = 0; m_done = 1; m_did = eid; end
      else m_xerr = 1;
    end
    if (free_i >= 0) begin
      m_v[free_i] = 1; m_id[free_i] = id; m_pc[free_i] = pc; m_cnt[free_i] = c;
    end
  endtask

  task automatic check_outputs();
    check("issue_valid", 32'(bus.issue_valid), 32'(m_iv));
    if (m_iv) begin
      check("issue_warp_id", 32'(bus.issue_warp_id), 32'(m_iid));
      check("issue_pc", bus.issue_pc, m_ipc);
      check("issue_mask", 32'(bus.issue_thread_mask), 32'(m_imask));
    end
    check("kernel_error", 32'(bus.kernel_error), 32'(m_kerr));
    check("warp_done", 32'(bus.warp_done), 32'(m_done));
    if (m_done) check("done_warp_id", 32'(bus.done_warp_id), 32'(m_did));
    check("exit_error", 32'(bus.exit_error), 32'(m_xerr));
    check("active_warps", 32'(bus.active_warps), 32'(model_active()));
  endtask

  // One clock: drive at negedge, check kernel_ready, model the edge, check at next negedge.
  task automatic apply(input bit r, input bit vk, input logic [2:0] c,
                       input logic [31:0] pc, input logic [3:0] id,
                       input bit ir, input bit ev, input logic [3:0] eid);
    rst = r;
    bus.valid_kernel = vk; bus.kernel_thread_count = c;
    bus.kernel_start_pc = pc; bus.kernel_warp_id = id;
    bus.issue_ready = ir; bus.exit_valid = ev; bus.exit_warp_id = eid;
    #1;
    check("kernel_ready", 32'(bus.kernel_ready), 32'(!r && model_free()));
    @(posedge clk);
    model_step(r, vk, c, pc, id, ir, ev, eid);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input bit ir);
    apply(0, 0, 3'd0, 32'h0, 4'd0, ir, 0, 4'd0);
  endtask

  initial begin
    logic [3:0] xid;
    m_rr = 0; m_iv = 0; m_iid = '0; m_ipc = '0; m_imask = '0; m_did = '0;
    for (int i = 0; i < NS; i++) begin m_v[i] = 0; m_id[i] = '0; m_pc[i] = '0; m_cnt[i] = '0; end

    // Reset: all outputs zero, ready low while rst is high.
    apply(1, 0, 3'd0, 32'h0, 4'd0, 0, 0, 4'd0);
    apply(1, 1, 3'd5, 32'h40, 4'd2, 1, 1, 4'd2);
    check("rst_ready", 32'(bus.kernel_ready), 32'd0);
    check("rst_issue_pc", bus.issue_pc, 32'd0);

    // Single warp, count 7: pcs 0x100, 0x104, 0x108, mask 7F.
    apply(0, 1, 3'd7, 32'h100, 4'd3, 1, 0, 4'd0);
    check("tp1_ready_after_rst", 32'(bus.kernel_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      idle(1);
      check("tp1_pc", bus.issue_pc, 32'h100 + 32'(4 * k));
      check("tp1_id", 32'(bus.issue_warp_id), 32'd3);
      check("tp1_mask", 32'(bus.issue_thread_mask), 32'h7F);
    end
    apply(0, 0, 3'd0, 32'h0, 4'd0, 1, 1, 4'd3);
    check("tp1_done", 32'(bus.warp_done), 32'd1);
    check("tp1_issue_off", 32'(bus.issue_valid), 32'd0);

    // Three warps, round-robin 1,2,5,1.
    apply(0, 1, 3'd4, 32'h0000, 4'd1, 0, 0, 4'd0);
    apply(0, 1, 3'd4, 32'h1000, 4'd2, 0, 0, 4'd0);
    apply(0, 1, 3'd4, 32'h2000, 4'd5, 0, 0, 4'd0);
    check("tp2_first_id", 32'(bus.issue_warp_id), 32'd1);
    check("tp2_first_pc", bus.issue_pc, 32'h0);
    idle(1);
    check("tp2_id2", 32'(bus.issue_warp_id), 32'd2);
    check("tp2_pc2", bus.issue_pc, 32'h1000);
    idle(1);
    check("tp2_id5", 32'(bus.issue_warp_id), 32'd5);
    check("tp2_pc5", bus.issue_pc, 32'h2000);
    idle(1);
    check("tp2_id1", 32'(bus.issue_warp_id), 32'd1);
    check("tp2_pc1", bus.issue_pc, 32'h4);

    // Fill, block a descriptor, free slot of id 5, descriptor lands.
    apply(0, 1, 3'd2, 32'h3000, 4'd7, 1, 0, 4'd0);
    apply(0, 1, 3'd2, 32'h4000, 4'd8, 1, 0, 4'd0);
    check("tp3_full_ready", 32'(bus.kernel_ready), 32'd0);
    check("tp3_full_active", 32'(bus.active_warps), 32'd4);
    apply(0, 1, 3'd2, 32'h4000, 4'd8, 1, 1, 4'd5);
    check("tp3_done", 32'(bus.warp_done), 32'd1);
    check("tp3_done_id", 32'(bus.done_warp_id), 32'd5);
    check("tp3_active", 32'(bus.active_warps), 32'd3);
    apply(0, 1, 3'd2, 32'h4000, 4'd8, 1, 0, 4'd0);
    check("tp3_active_refill", 32'(bus.active_warps), 32'd4);

    // Stall five cycles, then retire the stalled warp.
    for (int k = 0; k < 5; k++) idle(0);
    xid = m_iid;
    apply(0, 0, 3'd0, 32'h0, 4'd0, 0, 1, xid);
    check("tp4_flush", 32'(bus.issue_valid), 32'd0);
    check("tp4_done", 32'(bus.warp_done), 32'd1);
    idle(1);

    // Rejects: zero count, duplicate id, non-resident exit.
    apply(0, 1, 3'd0, 32'h5000, 4'd10, 1, 0, 4'd0);
    check("tp5_zero_err", 32'(bus.kernel_error), 32'd1);
    check("tp5_zero_active", 32'(bus.active_warps), 32'd3);
    xid = m_v[0] ? m_id[0] : m_id[1];
    apply(0, 1, 3'd3, 32'h5000, xid, 1, 0, 4'd0);
    check("tp5_dup_err", 32'(bus.kernel_error), 32'd1);
    check("tp5_dup_active", 32'(bus.active_warps), 32'd3);
    apply(0, 0, 3'd0, 32'h0, 4'd0, 1, 1, 4'd9);
    check("tp5_exit_err", 32'(bus.exit_error), 32'd1);

    // Mid-run reset, then PC wrap.
    apply(1, 0, 3'd0, 32'h0, 4'd0, 1, 1, 4'd1);
    check("tp6_rst_active", 32'(bus.active_warps), 32'd0);
    check("tp6_rst_done", 32'(bus.warp_done), 32'd0);
    apply(0, 1, 3'd3, 32'hFFFF_FFFC, 4'd4, 1, 0, 4'd0);
    idle(1);
    check("tp6_pc_top", bus.issue_pc, 32'hFFFF_FFFC);
    check("tp6_mask", 32'(bus.issue_thread_mask), 32'h07);
    idle(1);
    check("tp6_pc_wrap", bus.issue_pc, 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 800; n++) begin
      bit r, vk, ir, ev;
      logic [3:0] id, eid;
      int s;
      r   = ($urandom_range(0, 99) == 0);
      vk  = ($urandom_range(0, 2) != 0);
      ir  = ($urandom_range(0, 9) < 7);
      ev  = ($urandom_range(0, 4) == 0);
      id  = 4'($urandom_range(0, 15));
      s   = int'($urandom_range(0, NS - 1));
      eid = (m_v[s] && $urandom_range(0, 9) < 8) ? m_id[s] : 4'($urandom_range(0, 15));
      apply(r, vk, 3'($urandom_range(0, 7)), $urandom & 32'hFFFF_FFFC, id, ir, ev, eid);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
